// File: rtl/fp16_accumulator.sv
// FP16 dot-product reduction: sums a stream of FP16 terms into one result per vector.
// Each add runs through ALIGN/ADD/NORM. Denormals flush to zero, overflow saturates and rounding is toward zero.
module fp16_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t           state;
  logic [15:0]      acc, op;
  logic             last_q, ovf_q;
  logic [CNT_W-1:0] cnt;
  logic [13:0]      big_sig, sml_sig;
  logic [4:0]       big_exp;
  logic             big_sign, eff_sub;
  logic [14:0]      sum_q;

  // Zero/denormal become signed zero, and Inf/NaN become the largest finite magnitude.
  function automatic logic [15:0] canon(input logic [15:0] x);
    if (x[14:10] == 5'd0)       canon = {x[15], 15'h0};
    else if (x[14:10] == 5'd31) canon = {x[15], 15'h7BFF};
    else                        canon = x;
  endfunction

  assign in_ready = (state == IDLE);

  // ALIGN: order by magnitude, then shift the smaller significand right and keep G/R/S.
  logic [15:0] ca, co, bg, sm;
  logic [4:0]  d;
  logic [13:0] sm_full, sh;
  logic        ovf_in;
  always_comb begin
    ca      = canon(acc);
    co      = canon(op);
    bg      = (ca[14:0] >= co[14:0]) ? ca : co;
    sm      = (ca[14:0] >= co[14:0]) ? co : ca;
    d       = bg[14:10] - sm[14:10];
    sm_full = {|sm[14:10], sm[9:0], 3'b000};
    ovf_in  = (op[14:10] == 5'd31) || (acc[14:10] == 5'd31);
    if (d >= 5'd14) sh = {13'h0, |sm_full};
    else            sh = (sm_full >> d) | {13'h0, |(sm_full & ((14'h1 << d) - 14'h1))};
  end

  // NORM: carry-out or leading-zero shift, then truncate, saturate or flush.
  logic [3:0]  lz;
  logic [13:0] norm;
  logic [6:0]  e7;
  logic [9:0]  mant;
  logic [15:0] res;
  logic        res_ovf;
  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < 14; i++)
      if (sum_q[i]) lz = 4'(13 - i);
    norm    = sum_q[13:0] << lz;
    res_ovf = 1'b0;
    if (sum_q[14]) begin
      e7   = {2'b00, big_exp} + 7'd1;
      mant = sum_q[13:4];
    end else begin
      e7   = {2'b00, big_exp} - {3'b000, lz};
      mant = norm[12:3];
    end
    // An underflowed exponent wraps past 63, so bit 6 marks it.
    if (sum_q == 15'h0 || e7 == 7'd0 || e7[6]) res = 16'h0000;
    else if (e7 > 7'd30) begin
      res     = {big_sign, 15'h7BFF};
      res_ovf = 1'b1;
    end else res = {big_sign, e7[4:0], mant};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= 16'h0;
      op        <= 16'h0;
      last_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt       <= '0;
      big_sig   <= 14'h0;
      sml_sig   <= 14'h0;
      big_exp   <= 5'h0;
      big_sign  <= 1'b0;
      eff_sub   <= 1'b0;
      sum_q     <= 15'h0;
      out_valid <= 1'b0;
      out_sum   <= 16'h0;
      out_count <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= 16'h0;
      cnt       <= '0;
      ovf_q     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          op     <= in_data;
          last_q <= in_last;
          if (cnt != '1) cnt <= cnt + 1'b1;
          state  <= ALIGN;
        end
        ALIGN: begin
          big_sig  <= {|bg[14:10], bg[9:0], 3'b000};
          sml_sig  <= sh;
          big_exp  <= bg[14:10];
          big_sign <= bg[15];
          eff_sub  <= ca[15] ^ co[15];
          if (ovf_in) ovf_q <= 1'b1;
          state    <= ADD;
        end
        ADD: begin
          sum_q <= eff_sub ? {1'b0, big_sig} - {1'b0, sml_sig}
                           : {1'b0, big_sig} + {1'b0, sml_sig};
          state <= NORM;
        end
        NORM: begin
          acc <= res;
          if (res_ovf) ovf_q <= 1'b1;
          if (last_q) begin
            out_valid <= 1'b1;
            out_sum   <= res;
            out_count <= cnt;
            overflow  <= ovf_q | res_ovf;
            state     <= DONE;
          end else state <= IDLE;
        end
        DONE: begin
          acc   <= 16'h0;
          cnt   <= '0;
          ovf_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fp16_accumulator.md
# fp16_accumulator

Downstream reduction stage for the processing unit: consumes the stream of FP16 products (`P` qualified by `ready`) and sums them into one FP16 dot-product result per vector. A multi-cycle align/add/normalize FSM performs each addition, with denormal flush, saturation and round-toward-zero. A `last` flag closes a vector, emits the sum with a one-cycle valid strobe, and re-arms the accumulator.

## Interface
- `CNT_W`, default 8: width of the accepted-term counter.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `clear`  in  1  synchronous flush of accumulator, counter and flag; aborts any in-flight add.
- `in_valid`  in  1  product valid; driven from the processing unit's `ready`.
- `in_data`  in  16  FP16 product (1 sign, 5 exponent with bias 15, 10 fraction); driven from `P`.
- `in_last`  in  1  qualifies `in_data` as the final term of the vector.
- `in_ready`  out  1  high only in IDLE; a term is accepted on an edge with `in_valid && in_ready`.
- `out_valid`  out  1  one-cycle strobe carrying the finished sum.
- `out_sum`  out  16  FP16 sum, held stable until the next strobe.
- `out_count`  out  `CNT_W`  number of terms in `out_sum`; saturates at all-ones.
- `overflow`  out  1  sticky for the current vector; presented with `out_valid`; cleared when the next vector starts.

## Operation
- States: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE: `in_ready`=1. On accept, latch the operand and `in_last`, increment the counter, then go to ALIGN.
- ALIGN: compare the exponents of the accumulator and the operand, then right-shift the smaller significand.
  - Keep guard, round and sticky bits.
  - A shift of 14 or more leaves only the sticky bit.
- ADD: add the magnitudes if the signs match; otherwise subtract the smaller from the larger. The result takes the sign of the larger operand.
- NORM: normalize with a leading-zero count, then truncate toward zero, then write the accumulator. Go to DONE if the latched `in_last` is set, otherwise go to IDLE.
- DONE: drive `out_valid`=1 for one cycle and load `out_sum`, `out_count` and `overflow`. Zero the accumulator and counter, then go to IDLE.
- Arithmetic rules:
  - A zero exponent field (zero or denormal) is treated as 0.
  - An exponent field of 31 (Inf/NaN) is treated as ±0x7BFF and sets `overflow`.
  - The result is the exact sum truncated toward zero in magnitude. The GRS bits are required for subtraction.
  - A result exponent above 30 saturates to sign|0x7BFF and sets `overflow`.
  - A result exponent below 1 flushes to 0x0000.
  - An exact zero result is 0x0000, never 0x8000.
- `clear`: in the next cycle, accumulator=0, counter=0, `overflow`=0 and state=IDLE. The in-flight term is discarded, and no `out_valid` is issued. `clear` takes priority over an accept in the same cycle.
- `in_valid` while `in_ready`=0 is ignored, and no term is lost silently from the block's side. Upstream holds `in_valid` and `in_data` until accepted.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0x0000, `out_count`=0, `overflow`=0, accumulator=0, state IDLE.
- Non-last accept at edge T:
  - ALIGN in T+1, ADD in T+2, NORM in T+3.
  - IDLE with `in_ready`=1 in T+4.
  - Throughput is one term per 4 cycles.
- Last accept at edge T:
  - DONE in T+4, with `out_valid` high during T+4 and `out_sum` valid in the same cycle.
  - IDLE in T+5.
- `reset` or `clear` asserted in any state: registers take their reset values at the next edge. `out_valid` is never raised for an aborted vector.
- The counter saturates at 2^`CNT_W`−1; accumulation continues unaffected.
- A single-term vector with `in_last` returns that operand after flush/saturation, e.g. 0x0001 → 0x0000.

## Test plan
- Accept 0x4400 (4.0), then 0x4600 (6.0) with `in_last` → `out_sum`=0x4900 (10.0), `out_count`=2, `overflow`=0; `out_valid` exactly 4 cycles after the second accept.
- Accept 0x4400, then 0xC400 with last → 0x0000, never 0x8000.
- Rounding toward zero, each as a new vector:
  - 0x3C00 + 0x1400 → 0x3C01.
  - 0x3C00 + 0x1000 → 0x3C00.
  - 0x3C00 + 0x8C00 → 0x3BFF.
  - 0x3C00 + 0x0001 → 0x3C00 (denormal flushed).
- Accept 0x7BFF, then 0x7BFF with last → `out_sum`=0x7BFF, `overflow`=1. The next vector 0x3C00 with last → 0x3C00, `overflow`=0.
- Hold `in_valid` high continuously with 5 terms of 0x3C00, the last flagged → `in_ready` high 1 cycle in 4; `out_sum`=0x4500 (5.0), `out_count`=5.
- Assert `clear` during ADD of the second term, then send 0x4000 with last → `out_sum`=0x4000, `out_count`=1, no strobe from the aborted vector. Repeat with `reset` in NORM → all outputs return to their reset values the next cycle.
